rx_block_ap_axil_regs: RTL and testbench
========================================

Name: rx_block_ap_axil_regs

Overview:
AXI4-Lite slave register file that terminates the control bus of the RX_Block_AP IP. It is the responder to the AXI4-Lite master (VIP or PS interconnect) that writes and reads the block's configuration registers. It exposes the registers as a flat vector to the RX datapath. It supports one outstanding write and one outstanding read, handled independently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of read/write registers (1..2^(C_S_AXI_ADDR_WIDTH-2)).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  register contents; reg i at [32*i+31:32*i]
status_in  in  32  present only with RX_BLOCK_AP_STATUS_EN

Behaviour:
- Reset: all registers 0; all outputs 0. AWREADY/WREADY/ARREADY are registered and go to 1 on the first cycle after ARESET is sampled low. ARESET asserted mid-transaction abandons it: BVALID/RVALID drop next cycle and registers clear.
- Write FSM states are W_IDLE, W_ADDR, W_DATA and W_RESP.
  - W_IDLE: AWREADY=1, WREADY=1.
  - AW and W handshakes in the same cycle -> commit, go to W_RESP.
  - AW handshake only -> W_ADDR (AWREADY=0, WREADY=1); the W handshake there commits and moves to W_RESP.
  - W handshake only -> W_DATA (WREADY=0, AWREADY=1); the AW handshake there commits and moves to W_RESP.
- Commit: for an in-range index (<NUM_REGS), each byte with WSTRB[b]=1 is updated. reg_out shows the new value the cycle after commit. BRESP=OKAY (2'b00). For an out-of-range index, no register changes and BRESP=SLVERR (2'b10).
- W_RESP: BVALID=1, both write readies 0. BVALID and BRESP are held stable until BREADY=1, then the FSM returns to W_IDLE.
- Write latency: BVALID rises the cycle after commit.
- Read FSM states are R_IDLE and R_DATA.
  - R_IDLE: ARREADY=1. An AR handshake latches RDATA/RRESP and moves to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA/RRESP are held until RREADY=1, then the FSM returns to R_IDLE.
  - Read latency: RVALID rises the cycle after the AR handshake.
- Out-of-range read returns RDATA=0 and RRESP=SLVERR.
- If a read handshake and a write commit hit the same register in the same cycle, the read returns the pre-write value.
- addr[1:0] and the PROT inputs are ignored. Read and write channels never block each other.

Optional Feature:
Macro RX_BLOCK_AP_STATUS_EN.
- Defined: port status_in exists. Word index NUM_REGS is a read-only register. Reads return status_in sampled at the AR handshake with RRESP=OKAY. Writes to that index return SLVERR and change nothing. NUM_REGS must be below 2^(C_S_AXI_ADDR_WIDTH-2).
- Undefined: no status_in port, and index NUM_REGS is out-of-range like any other index.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C (WSTRB=0xF), then read back -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY, and reg_out=0x00000004_00000003_00000002_00000001.
- Reg0=0xAABBCCDD, then write 0x11223344 with WSTRB=0x5 -> reads 0xAA22CC44.
- Present WVALID 3 cycles before AWVALID (addr 0x08, data 0x5A5A5A5A) -> WREADY low until the AW handshake, one BVALID, reg2=0x5A5A5A5A. Repeat with AW first.
- Write and read address 0x10 (NUM_REGS=4, macro off) -> BRESP=2'b10, RDATA=0, RRESP=2'b10, regs unchanged.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data stable, no new AW/AR accepted. Assert ARESET during a held BVALID -> BVALID=0 and reg_out=0 next cycle.
- With RX_BLOCK_AP_STATUS_EN defined and status_in=0xDEADBEEF, read 0x10 -> 0xDEADBEEF/OKAY. Write 0x10 -> SLVERR.

Source files
------------

// File: rtl/rx_block_ap_axil_regs.sv
// AXI4-Lite register file for RX_Block_AP: NUM_REGS RW words on reg_out, plus a RO status word when RX_BLOCK_AP_STATUS_EN is defined.
// BVALID/RVALID rise one cycle after commit / AR handshake; responses held until BREADY/RREADY, readies low meanwhile.
module rx_block_ap_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]        reg_out
`ifdef RX_BLOCK_AP_STATUS_EN
  ,
  input  logic [31:0]                   status_in
`endif
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];

  logic              aw_hs, w_hs, ar_hs;
  logic              commit, commit_hit;
  logic [IDX_W-1:0]  commit_idx, rd_idx;
  logic [31:0]       commit_data;
  logic [3:0]        commit_strb;

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID & wready_q;
  assign ar_hs  = S_AXI_ARVALID & arready_q;
  assign rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // Commit takes address and data from the bus or from whichever half was latched first.
  always_comb begin
    w_state_d   = w_state_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_idx  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    commit_data = S_AXI_WDATA;
    commit_strb = S_AXI_WSTRB;
    commit_hit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          w_state_d = W_ADDR;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = W_DATA;
        end
      end
      W_ADDR: begin
        commit_idx = aw_idx_q;
        if (w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_DATA: begin
        commit_data = wdata_q;
        commit_strb = wstrb_q;
        if (aw_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_idx == IDX_W'(i)) commit_hit = 1'b1;
    end
    if (commit) bresp_d = commit_hit ? RESP_OKAY : RESP_SLVERR;
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (commit_idx == IDX_W'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (commit_strb[b]) regs_d[i][8*b +: 8] = commit_data[8*b +: 8];
        end
      end
    end
  end

  // Read data comes from regs_q, so a same-cycle write to the word is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
`ifdef RX_BLOCK_AP_STATUS_EN
          if (rd_idx == IDX_W'(NUM_REGS)) begin
            rdata_d = status_in;
            rresp_d = RESP_OKAY;
          end
`endif
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      regs_q    <= '{default: '0};
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_rx_block_ap_axil_regs.sv
// Directed bench for rx_block_ap_axil_regs: vector table of single transactions plus hand-written channel-ordering,
// backpressure, collision and reset sequences.
module tb_rx_block_ap_axil_regs;

  logic         aclk;
  logic         areset;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;
  logic [31:0]  status_in;

`ifdef RX_BLOCK_AP_STATUS_EN
  localparam logic [31:0] EXP_R10      = 32'hDEADBEEF;
  localparam logic [1:0]  EXP_R10_RESP = 2'b00;
`else
  localparam logic [31:0] EXP_R10      = 32'h0;
  localparam logic [1:0]  EXP_R10_RESP = 2'b10;
`endif

  rx_block_ap_axil_regs dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out)
`ifdef RX_BLOCK_AP_STATUS_EN
    , .status_in(status_in)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic         is_wr;
    logic [5:0]   addr;
    logic [31:0]  data;
    logic [3:0]   strb;
    logic [31:0]  exp_rdata;
    logic [1:0]   exp_resp;
    logic [127:0] exp_reg_out;
  } vec_t;

  function automatic vec_t mk(input logic is_wr, input logic [5:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_rdata,
                              input logic [1:0] exp_resp, input logic [127:0] exp_reg_out);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_reg_out = exp_reg_out;
    return v;
  endfunction

  // Called and returns on a negedge; handshakes are observed at negedge and complete at the next posedge.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    logic aw_done, w_done, aw_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge aclk);
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    check("wr_bvalid_latency", bvalid, 1'b1);
    for (int c = 0; c < 20 && !bvalid; c++) @(negedge aclk);
    resp = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("wr_bvalid_clear", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ar_done, ar_hs;
    araddr = addr; arvalid = 1'b1; ar_done = 1'b0;
    for (int c = 0; c < 20 && !ar_done; c++) begin
      ar_hs = arvalid && arready;
      @(negedge aclk);
      if (ar_hs) begin arvalid = 1'b0; ar_done = 1'b1; end
    end
    arvalid = 1'b0;
    check("rd_handshake", ar_done, 1'b1);
    check("rd_rvalid_latency", rvalid, 1'b1);
    for (int c = 0; c < 20 && !rvalid; c++) @(negedge aclk);
    data = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rd_rvalid_clear", rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  vec_t        vecs[18];
  logic [1:0]  resp;
  logic [31:0] data;

  initial begin
    vecs[0]  = mk(1, 6'h00, 32'h1, 4'hF, 0, 2'b00, {32'h0, 32'h0, 32'h0, 32'h1});
    vecs[1]  = mk(1, 6'h04, 32'h2, 4'hF, 0, 2'b00, {32'h0, 32'h0, 32'h2, 32'h1});
    vecs[2]  = mk(1, 6'h08, 32'h3, 4'hF, 0, 2'b00, {32'h0, 32'h3, 32'h2, 32'h1});
    vecs[3]  = mk(1, 6'h0C, 32'h4, 4'hF, 0, 2'b00, {32'h4, 32'h3, 32'h2, 32'h1});
    vecs[4]  = mk(0, 6'h00, 0, 0, 32'h1, 2'b00, {32'h4, 32'h3, 32'h2, 32'h1});
    vecs[5]  = mk(0, 6'h04, 0, 0, 32'h2, 2'b00, {32'h4, 32'h3, 32'h2, 32'h1});
    vecs[6]  = mk(0, 6'h08, 0, 0, 32'h3, 2'b00, {32'h4, 32'h3, 32'h2, 32'h1});
    vecs[7]  = mk(0, 6'h0C, 0, 0, 32'h4, 2'b00, {32'h4, 32'h3, 32'h2, 32'h1});
    vecs[8]  = mk(1, 6'h00, 32'hAABBCCDD, 4'hF, 0, 2'b00, {32'h4, 32'h3, 32'h2, 32'hAABBCCDD});
    vecs[9]  = mk(1, 6'h00, 32'h11223344, 4'h5, 0, 2'b00, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[10] = mk(0, 6'h00, 0, 0, 32'hAA22CC44, 2'b00, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[11] = mk(1, 6'h10, 32'hFFFFFFFF, 4'hF, 0, 2'b10, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[12] = mk(0, 6'h10, 0, 0, EXP_R10, EXP_R10_RESP, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[13] = mk(0, 6'h3C, 0, 0, 32'h0, 2'b10, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[14] = mk(1, 6'h3C, 32'hFFFFFFFF, 4'hF, 0, 2'b10, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[15] = mk(0, 6'h0D, 0, 0, 32'h4, 2'b00, {32'h4, 32'h3, 32'h2, 32'hAA22CC44});
    vecs[16] = mk(1, 6'h07, 32'h0000BEEF, 4'h3, 0, 2'b00, {32'h4, 32'h3, 32'h0000BEEF, 32'hAA22CC44});
    vecs[17] = mk(0, 6'h04, 0, 0, 32'h0000BEEF, 2'b00, {32'h4, 32'h3, 32'h0000BEEF, 32'hAA22CC44});

    areset = 1'b1; status_in = 32'hDEADBEEF;
    awaddr = '0; awprot = 3'b111; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b111; arvalid = 1'b0; rready = 1'b0;

    repeat (3) @(negedge aclk);
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
    check("rst_reg_out", reg_out, 128'h0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, data, resp);
        check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
      end
      check($sformatf("vec%0d_reg_out", i), reg_out, vecs[i].exp_reg_out);
    end

    // W leads AW by three cycles.
    wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("wfirst_wready_c%0d", c), {wready, awready, bvalid}, 3'b010);
      @(negedge aclk);
    end
    awaddr = 6'h08; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    check("wfirst_bvalid", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("wfirst_bvalid_once", bvalid, 1'b0);
    check("wfirst_reg2", reg_out[95:64], 32'h5A5A5A5A);

    // AW leads W by three cycles.
    awaddr = 6'h04; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("awfirst_awready_c%0d", c), {awready, wready, bvalid}, 3'b010);
      @(negedge aclk);
    end
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    check("awfirst_bvalid", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("awfirst_bvalid_once", bvalid, 1'b0);
    check("awfirst_reg1", reg_out[63:32], 32'hA5A5A5A5);

    // Same-cycle read and write of reg0: read sees the old value.
    awaddr = 6'h00; wdata = 32'h00000099; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h00; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_rvalid_bvalid", {rvalid, bvalid}, 2'b11);
    check("coll_rdata_old", rdata, 32'hAA22CC44);
    check("coll_resps", {bresp, rresp}, 4'b0000);
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    check("coll_reg0_new", reg_out[31:0], 32'h00000099);

    // Hold both responses for five cycles with BREADY/RREADY low.
    awaddr = 6'h0C; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 6'h08; arvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0; awaddr = 6'h00; araddr = 6'h00;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold_b_c%0d", c), {bvalid, bresp, awready, wready}, 5'b10000);
      check($sformatf("hold_r_c%0d", c), {rvalid, rresp, arready, rdata}, {4'b1000, 32'h5A5A5A5A});
      @(negedge aclk);
    end
    awvalid = 1'b0; arvalid = 1'b0;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("hold_r_release", {rvalid, arready}, 2'b01);
    check("hold_b_still", {bvalid, reg_out[127:96]}, {1'b1, 32'h12345678});

    // Reset while BVALID is still held.
    areset = 1'b1;
    @(negedge aclk);
    check("midrst_bvalid", {bvalid, awready, wready, arready}, 4'b0000);
    check("midrst_reg_out", reg_out, 128'h0);
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_readies", {awready, wready, arready}, 3'b111);
    axi_read(6'h0C, data, resp);
    check("midrst_read_reg3", {data, resp}, {32'h0, 2'b00});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
